exe_stage: RTL
==============

# exe_stage

Execute stage of the five-stage in-order pipeline, between ID and MEM. It latches `ID_to_EXE_bus` under valid/allow-in handshaking and computes single-cycle ALU results. Signed and unsigned divide/modulo run on an iterative radix-2 divider that stalls the stage. It issues the word data-RAM request on handoff and forwards `EXE_to_MEM_bus` to MEM.

## Interface
- No parameters; bus widths and opcodes come from `myCPU.h`.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `ID_to_EXE_bus` in 142: `{PC_plus_4[141:110], src1[109:78], src2[77:46], alu_op[45:42], mem_en[41], mem_we[40], store_data[39:8], RegFile_target_w_addr[7:3], sel_rf_w_data[2:1], sel_rf_w_en[0]}`.
- `ID_to_EXE_valid` in 1: upstream payload valid.
- `EXE_allow_in` out 1: stage can accept this cycle.
- `MEM_allow_in` in 1: downstream can accept.
- `EXE_to_MEM_valid` out 1: payload valid to MEM.
- `EXE_to_MEM_bus` out 73: `{PC_plus_4[72:41], alu_res[40:9], RegFile_target_w_addr[7:3], sel_rf_w_data[2:1], sel_rf_w_en[0]}`. Bit 8 is 0.
- `data_ram_en` out 1, `data_ram_we` out 4, `data_ram_addr` out 32, `data_ram_w_data` out 32: synchronous word RAM port; read data returns to MEM the next cycle.

## Operation
- Handshake: `EXE_allow_in = ~EXE_valid | (EXE_ready_go & MEM_allow_in)`. `EXE_to_MEM_valid = EXE_valid & EXE_ready_go`.
- `EXE_valid` loads `ID_to_EXE_valid` when `EXE_allow_in` is high. The payload register loads only on `ID_to_EXE_valid & EXE_allow_in`.
- `alu_op` encodings:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLL, 9 SRL, 10 SRA: shift amount `src2[4:0]`.
  - 11 LUI: result is `src2`.
  - 12 DIV, 13 DIVU, 14 MOD, 15 MODU.
- Non-divide ops: 32-bit wrap-around arithmetic; `EXE_ready_go = 1`.
- Divider FSM: IDLE → RUN → DONE → IDLE.
  - IDLE→RUN when `EXE_valid` and op is 12–15. Latches |src1|, |src2| (signed ops) or raw values; iteration counter = 0.
  - RUN performs one restoring shift-subtract step per cycle, 32 cycles, then DONE.
  - In DONE, `EXE_ready_go = 1` and the result is held.
  - DONE→IDLE on `EXE_to_MEM_valid & MEM_allow_in`.
  - `EXE_ready_go = 0` in IDLE/RUN whenever a divide op occupies EXE.
- Signed result fixup:
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Divide by zero: quotient 0xFFFFFFFF and remainder = src1 for both signed and unsigned ops. Same 32-cycle timing; no early exit.
- Memory request on handoff only: `data_ram_en = mem_en & EXE_to_MEM_valid & MEM_allow_in`.
  - `data_ram_we = {4{mem_we}}`, gated identically.
  - `data_ram_addr = alu_res`; `data_ram_w_data = store_data`.

## Timing
- Reset values: `EXE_valid` 0, FSM IDLE, payload register 0. Therefore `EXE_to_MEM_valid` 0, `EXE_to_MEM_bus` 0, `data_ram_en` 0, `data_ram_we` 0, `data_ram_addr` 0, `data_ram_w_data` 0.
- `EXE_allow_in` = 1 during reset.
- Non-divide ops: accepted at edge N, handed off at edge N+1 if `MEM_allow_in`. Full throughput.
- Divide ops: the first EXE cycle is C0. RUN spans C1–C32; DONE and `EXE_to_MEM_valid` start in C33. Handoff is no earlier than edge C33→C34.
- MEM stall in DONE: FSM stays in DONE, and the bus and result stay stable. No RAM request is issued until handoff.
- `reset` low mid-RUN: the divide is discarded immediately, FSM goes IDLE and `EXE_valid` goes 0.
- Back-to-back divides: the second enters IDLE→RUN the cycle after the first hands off.

## Configuration
- `EXE_DIV_EN` defined: divider FSM and `div_iter` are present, with behaviour as above.
- `EXE_DIV_EN` undefined: no FSM or divider. Ops 12–15 complete in one cycle with `alu_res = 0`, and `EXE_ready_go` is always 1.

## Structure
- `myCPU.h` holds:
  - `ID_TO_EXE_BUS_WD` (142) and `EXE_TO_MEM_BUS_WD` (73).
  - `alu_op` opcode constants.
  - Divider state encodings.
- Sub-module `div_iter`: operand latch, 64-bit partial-remainder shift register, counter and FSM. Exposes start, signed flag, done, quotient and remainder. Sign fixup also lives in `div_iter`; `exe_stage` owns the handshake.

## Test plan
- ADD 0x7FFFFFFF+1 followed by SUB 0−1, `MEM_allow_in`=1 → consecutive handoffs with `alu_res` 0x80000000, then 0xFFFFFFFF.
- DIV −7/2 → `EXE_to_MEM_valid` first high in C33, `alu_res` 0xFFFFFFFD. MOD −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIV 5/0 → 0xFFFFFFFF. MODU 5/0 → 5. DIV 0x80000000/−1 → 0x80000000.
- Divide reaches DONE with `MEM_allow_in`=0 for 4 cycles → bus held, `EXE_allow_in`=0 throughout, handoff on the fifth cycle.
- Store (`mem_en`=1, `mem_we`=1, ADD 0x100+4, `store_data` 0xDEADBEEF) with MEM stalled 2 cycles → `data_ram_en` and `data_ram_we`=0xF only on the handoff cycle, `data_ram_addr` 0x104.
- `reset` asserted at C10 of a DIV → all outputs at reset values in the same cycle. After release, an ADD completes normally.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcodes, bus payload layouts and divider states for the execute stage.
package exe_stage_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned RF_ADDR_W         = 5;
  localparam int unsigned SHAMT_W           = 5;
  localparam int unsigned DIV_CNT_W         = 5;
  localparam int unsigned ID_TO_EXE_BUS_WD  = 142;
  localparam int unsigned EXE_TO_MEM_BUS_WD = 73;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLT  = 4'd2,  ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,  ALU_OR   = 4'd5,  ALU_XOR  = 4'd6,  ALU_NOR  = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11,
    ALU_DIV  = 4'd12, ALU_DIVU = 4'd13, ALU_MOD  = 4'd14, ALU_MODU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]    pc_plus_4;
    logic [DATA_W-1:0]    src1;
    logic [DATA_W-1:0]    src2;
    alu_op_e              alu_op;
    logic                 mem_en;
    logic                 mem_we;
    logic [DATA_W-1:0]    store_data;
    logic [RF_ADDR_W-1:0] rf_w_addr;
    logic [1:0]           sel_rf_w_data;
    logic                 sel_rf_w_en;
  } id_to_exe_t;

  typedef struct packed {
    logic [DATA_W-1:0]    pc_plus_4;
    logic [DATA_W-1:0]    alu_res;
    logic                 rsvd;
    logic [RF_ADDR_W-1:0] rf_w_addr;
    logic [1:0]           sel_rf_w_data;
    logic                 sel_rf_w_en;
  } exe_to_mem_t;

  // Single-cycle ALU; divide opcodes yield 0 here and are overridden by the divider when present.
  function automatic logic [DATA_W-1:0] alu_simple(input alu_op_e op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [SHAMT_W-1:0] sh;
    logic [DATA_W-1:0]  r;
    sh = b[SHAMT_W-1:0];
    r  = '0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = DATA_W'($signed(a) < $signed(b));
      ALU_SLTU: r = DATA_W'(a < b);
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = DATA_W'($signed(a) >>> sh);
      ALU_LUI:  r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring divider with sign fixup; present only when EXE_DIV_EN is defined.
// Runs 32 steps after start, then holds the result in DONE until ack.
`ifdef EXE_DIV_EN
module div_iter
  import exe_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              ack,
  output logic              done_c,
  output logic [DATA_W-1:0] quot_c,
  output logic [DATA_W-1:0] rem_c
);

  div_state_e            state_q, state_d;
  logic [2*DATA_W-1:0]   pr_q, pr_d;
  logic [DATA_W-1:0]     dvsr_q, dvsr_d;
  logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  div0_q, div0_d;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     abs_a, abs_b;

  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    abs_a   = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
    abs_b   = (is_signed && divisor[DATA_W-1])  ? -divisor  : divisor;
    // Shifted partial remainder minus divisor; no borrow means the quotient bit is 1.
    diff    = pr_q[2*DATA_W-1:DATA_W-1] - {1'b0, dvsr_q};
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_RUN;
          pr_d    = {{DATA_W{1'b0}}, abs_a};
          dvsr_d  = abs_b;
          cnt_d   = '0;
          q_neg_d = is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          r_neg_d = is_signed & dividend[DATA_W-1];
          div0_d  = (divisor == '0);
        end
      end
      DIV_RUN: begin
        pr_d  = {(diff[DATA_W] ? pr_q[2*DATA_W-2:DATA_W-1] : diff[DATA_W-1:0]),
                 pr_q[DATA_W-2:0], ~diff[DATA_W]};
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (ack) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    done_c = (state_q == DIV_DONE);
    rem_c  = r_neg_q ? -pr_q[2*DATA_W-1:DATA_W] : pr_q[2*DATA_W-1:DATA_W];
    if (div0_q)       quot_c = '1;
    else if (q_neg_q) quot_c = -pr_q[DATA_W-1:0];
    else              quot_c = pr_q[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      pr_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
    end
  end

endmodule
`endif

// File: rtl/exe_stage.sv
// Execute stage: latches the ID payload, computes the ALU result and hands off to MEM with the RAM request.
// Define EXE_DIV_EN to build the iterative divider for ops 12-15; otherwise those ops return 0 in one cycle.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_TO_EXE_BUS_WD-1:0]  ID_to_EXE_bus,
  input  logic                         ID_to_EXE_valid,
  output logic                         EXE_allow_in,
  input  logic                         MEM_allow_in,
  output logic                         EXE_to_MEM_valid,
  output logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  output logic                         data_ram_en,
  output logic [3:0]                   data_ram_we,
  output logic [DATA_W-1:0]            data_ram_addr,
  output logic [DATA_W-1:0]            data_ram_w_data
);

  logic              exe_valid_q, exe_valid_d;
  id_to_exe_t        pl_q, pl_d;
  logic              exe_ready_go;
  logic              handoff;
  logic [DATA_W-1:0] alu_res;
  exe_to_mem_t       out_bus;

`ifdef EXE_DIV_EN
  logic              is_div, div_start, div_signed, div_done;
  logic [DATA_W-1:0] div_quot, div_rem;

  always_comb begin
    is_div     = pl_q.alu_op inside {ALU_DIV, ALU_DIVU, ALU_MOD, ALU_MODU};
    div_signed = pl_q.alu_op inside {ALU_DIV, ALU_MOD};
    div_start  = exe_valid_q & is_div;
  end

  div_iter u_div_iter (
    .clk       (clk),
    .rst_n     (reset),
    .start     (div_start),
    .is_signed (div_signed),
    .dividend  (pl_q.src1),
    .divisor   (pl_q.src2),
    .ack       (handoff),
    .done_c    (div_done),
    .quot_c    (div_quot),
    .rem_c     (div_rem)
  );

  always_comb begin
    exe_ready_go = ~is_div | div_done;
    if (!is_div)                                    alu_res = alu_simple(pl_q.alu_op, pl_q.src1, pl_q.src2);
    else if (pl_q.alu_op inside {ALU_DIV, ALU_DIVU}) alu_res = div_quot;
    else                                            alu_res = div_rem;
  end
`else
  always_comb begin
    exe_ready_go = 1'b1;
    alu_res      = alu_simple(pl_q.alu_op, pl_q.src1, pl_q.src2);
  end
`endif

  // Valid/allow-in handshake; payload only loads on an accepted transfer.
  always_comb begin
    EXE_allow_in     = ~exe_valid_q | (exe_ready_go & MEM_allow_in);
    EXE_to_MEM_valid = exe_valid_q & exe_ready_go;
    handoff          = EXE_to_MEM_valid & MEM_allow_in;
    exe_valid_d      = EXE_allow_in ? ID_to_EXE_valid : exe_valid_q;
    pl_d             = (ID_to_EXE_valid & EXE_allow_in) ? id_to_exe_t'(ID_to_EXE_bus) : pl_q;
  end

  always_comb begin
    out_bus.pc_plus_4     = pl_q.pc_plus_4;
    out_bus.alu_res       = alu_res;
    out_bus.rsvd          = 1'b0;
    out_bus.rf_w_addr     = pl_q.rf_w_addr;
    out_bus.sel_rf_w_data = pl_q.sel_rf_w_data;
    out_bus.sel_rf_w_en   = pl_q.sel_rf_w_en;
    EXE_to_MEM_bus        = out_bus;
    data_ram_en           = pl_q.mem_en & handoff;
    data_ram_we           = {4{pl_q.mem_en & pl_q.mem_we & handoff}};
    data_ram_addr         = alu_res;
    data_ram_w_data       = pl_q.store_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exe_valid_q <= 1'b0;
      pl_q        <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      pl_q        <= pl_d;
    end
  end

endmodule
